// File: rtl/logic_box_cfg_pkg.sv
// Shared definitions for the logic box configuration loader: frame layout,
// field widths/offsets, FSM state encoding and counter sizing.
// Optional feature macro: CFG_PARITY_EN (trailing even-parity bit per load).
package logic_box_cfg_pkg;

    // One tile frame, MSB first: BLEout[3:0], direction[1:0], sel, lut[15:0]
    localparam int CFG_FRAME_W = 23;

    localparam int LUT_W = 16;
    localparam int SEL_W = 1;
    localparam int DIR_W = 2;
    localparam int BLE_W = 4;

    localparam int LUT_OFF = 0;
    localparam int SEL_OFF = LUT_OFF + LUT_W;   // 16
    localparam int DIR_OFF = SEL_OFF + SEL_W;   // 17
    localparam int BLE_OFF = DIR_OFF + DIR_W;   // 19

`ifdef CFG_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        COMMIT = 2'd3
    } cfg_state_e;

    // Counter must hold the full bit count of a load (payload plus parity)
    function automatic int cnt_width(input int num_tiles);
        return $clog2(num_tiles * CFG_FRAME_W + PARITY_BITS + 1);
    endfunction

endpackage

// File: rtl/logic_box_cfg_loader_if.sv
// Serial configuration port and loader status signals.
//
// Handshake: a bit on cfg_data is transferred on a rising clk edge where
// cfg_valid && cfg_ready are both high. cfg_ready depends only on loader
// state (never on cfg_valid), so the master may sample it any time in the
// cycle. cfg_valid while cfg_ready is low is simply ignored.
interface logic_box_cfg_loader_if;
    logic cfg_start;
    logic cfg_data;
    logic cfg_valid;
    logic cfg_ready;
    logic cfg_busy;
    logic cfg_done;
    logic cfg_err;
    logic cfg_active;

    modport master (
        output cfg_start, cfg_data, cfg_valid,
        input  cfg_ready, cfg_busy, cfg_done, cfg_err, cfg_active
    );

    modport slave (
        input  cfg_start, cfg_data, cfg_valid,
        output cfg_ready, cfg_busy, cfg_done, cfg_err, cfg_active
    );
endinterface

// File: rtl/logic_box_cfg_unpack.sv
// Purely combinational slicer: splits one 23-bit tile frame into the four
// logic box configuration fields.
module logic_box_cfg_unpack
    import logic_box_cfg_pkg::*;
(
    input  logic [CFG_FRAME_W-1:0] frame_i,
    output logic [LUT_W-1:0]       lut_o,
    output logic [SEL_W-1:0]       sel_o,
    output logic [DIR_W-1:0]       dir_o,
    output logic [BLE_W-1:0]       ble_o
);

    assign lut_o = frame_i[LUT_OFF +: LUT_W];
    assign sel_o = frame_i[SEL_OFF +: SEL_W];
    assign dir_o = frame_i[DIR_OFF +: DIR_W];
    assign ble_o = frame_i[BLE_OFF +: BLE_W];

endmodule

// File: rtl/logic_box_cfg_loader.sv
// Serial configuration loader for NUM_TILES logic boxes. Bits are shifted
// into a shadow register and copied to the output registers in a single
// COMMIT cycle, so the tiles never see a partial configuration.
// Optional feature macro: CFG_PARITY_EN (trailing even-parity bit, cfg_err).
module logic_box_cfg_loader
    import logic_box_cfg_pkg::*;
#(
    parameter  int NUM_TILES = 4,
    localparam int CNT_W     = cnt_width(NUM_TILES)
) (
    input  logic                     clk,
    input  logic                     reset,
    logic_box_cfg_loader_if.slave    cfg,
    output logic [16*NUM_TILES-1:0]  lut_o,
    output logic [NUM_TILES-1:0]     sel_o,
    output logic [2*NUM_TILES-1:0]   sel_direction_o,
    output logic [4*NUM_TILES-1:0]   sel_direction_BLEout_o,
    output cfg_state_e               dbg_state_o,
    output logic [CNT_W-1:0]         dbg_bit_cnt_o
);

    localparam int PAYLOAD_W = NUM_TILES * CFG_FRAME_W;

    cfg_state_e             state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [PAYLOAD_W-1:0]   shadow_q, shadow_d;
    logic [16*NUM_TILES-1:0] lut_q, lut_d, unp_lut;
    logic [NUM_TILES-1:0]   sel_q, sel_d, unp_sel;
    logic [2*NUM_TILES-1:0] dir_q, dir_d, unp_dir;
    logic [4*NUM_TILES-1:0] ble_q, ble_d, unp_ble;
    logic                   done_q, done_d;
    logic                   active_q, active_d;
    logic                   ready, busy;
    logic                   accept;
    logic                   start_ok;
    logic                   last_payload;

    assign accept       = cfg.cfg_valid && ready;
    assign start_ok     = (state_q == IDLE) && cfg.cfg_start;
    assign last_payload = (bit_cnt_q == CNT_W'(PAYLOAD_W - 1));

    // Tile 0 is sent first, so it ends up in the most significant frame
    for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
        logic_box_cfg_unpack u_unpack (
            .frame_i (shadow_q[(NUM_TILES-1-t)*CFG_FRAME_W +: CFG_FRAME_W]),
            .lut_o   (unp_lut[16*t +: 16]),
            .sel_o   (unp_sel[t +: 1]),
            .dir_o   (unp_dir[2*t +: 2]),
            .ble_o   (unp_ble[4*t +: 4])
        );
    end

`ifdef CFG_PARITY_EN
    logic par_q, par_d;
    logic err_q, err_d;
    logic par_ok;

    // Even parity: running XOR of payload plus the parity bit must be 0
    assign par_ok = ~(par_q ^ cfg.cfg_data);

    // Parity accumulator and sticky error flag
    always_comb begin
        par_d = par_q;
        err_d = err_q;
        if (start_ok) begin
            par_d = 1'b0;
            err_d = 1'b0;
        end else if (accept && (state_q == SHIFT)) begin
            par_d = par_q ^ cfg.cfg_data;
        end else if (accept && (state_q == PARITY) && !par_ok) begin
            err_d = 1'b1;
        end
    end

    // Parity registers
    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            par_q <= par_d;
            err_q <= err_d;
        end
    end

    assign cfg.cfg_err = err_q;
`else
    assign cfg.cfg_err = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cfg.cfg_start) state_d = SHIFT;
            end
            SHIFT: begin
                if (accept && last_payload) begin
`ifdef CFG_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = COMMIT;
`endif
                end
            end
            PARITY: begin
`ifdef CFG_PARITY_EN
                if (accept) state_d = par_ok ? COMMIT : IDLE;
`else
                state_d = IDLE;
`endif
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: ready while taking bits, busy whenever not idle
    always_comb begin
        ready = (state_q == SHIFT) || (state_q == PARITY);
        busy  = (state_q != IDLE);
    end

    // Counter, shadow shift register and commit of the unpacked shadow
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shadow_d  = shadow_q;
        lut_d     = lut_q;
        sel_d     = sel_q;
        dir_d     = dir_q;
        ble_d     = ble_q;
        done_d    = (state_q == COMMIT);
        active_d  = active_q || (state_q == COMMIT);
        if (start_ok) begin
            bit_cnt_d = '0;
            shadow_d  = '0;
        end else if (accept) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (state_q == SHIFT) shadow_d = {shadow_q[PAYLOAD_W-2:0], cfg.cfg_data};
        end
        if (state_q == COMMIT) begin
            lut_d = unp_lut;
            sel_d = unp_sel;
            dir_d = unp_dir;
            ble_d = unp_ble;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q <= '0;
            shadow_q  <= '0;
            lut_q     <= '0;
            sel_q     <= '0;
            dir_q     <= '0;
            ble_q     <= '0;
            done_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shadow_q  <= shadow_d;
            lut_q     <= lut_d;
            sel_q     <= sel_d;
            dir_q     <= dir_d;
            ble_q     <= ble_d;
            done_q    <= done_d;
            active_q  <= active_d;
        end
    end

    assign cfg.cfg_ready          = ready;
    assign cfg.cfg_busy           = busy;
    assign cfg.cfg_done           = done_q;
    assign cfg.cfg_active         = active_q;
    assign lut_o                  = lut_q;
    assign sel_o                  = sel_q;
    assign sel_direction_o        = dir_q;
    assign sel_direction_BLEout_o = ble_q;
    assign dbg_state_o            = state_q;
    assign dbg_bit_cnt_o          = bit_cnt_q;

endmodule

// File: tb/tb_logic_box_cfg_loader.sv
// Bench for logic_box_cfg_loader with NUM_TILES=2: directed streams, an
// expected-configuration queue filled by the stimulus, and a monitor that
// pops and compares on every cfg_done pulse.
module tb_logic_box_cfg_loader;
    import logic_box_cfg_pkg::*;

    localparam int NUM_TILES = 2;
    localparam int PAYLOAD_W = NUM_TILES * CFG_FRAME_W;
    localparam int CNT_W     = cnt_width(NUM_TILES);
    localparam int WORD_W    = 46;

    // Stream A: tile0 = 0001/10/1/A5A5, tile1 = 1000/01/0/8001
    localparam logic [PAYLOAD_W-1:0] STREAM_A =
        {4'b0001, 2'b10, 1'b1, 16'hA5A5, 4'b1000, 2'b01, 1'b0, 16'h8001};
    // Stream B: tile0 = 0110/11/0/1234, tile1 = 0011/00/1/FFFE
    localparam logic [PAYLOAD_W-1:0] STREAM_B =
        {4'b0110, 2'b11, 1'b0, 16'h1234, 4'b0011, 2'b00, 1'b1, 16'hFFFE};
    // Hand-computed output words {lut_o, sel_o, sel_direction_o, BLEout_o}
    localparam logic [WORD_W-1:0] WORD_A = {32'h8001A5A5, 2'b01, 4'b0110, 8'h81};
    localparam logic [WORD_W-1:0] WORD_B = {32'hFFFE1234, 2'b10, 4'b0011, 8'h36};

    logic clk;
    logic reset;
    logic [16*NUM_TILES-1:0] lut_o;
    logic [NUM_TILES-1:0]    sel_o;
    logic [2*NUM_TILES-1:0]  dir_o;
    logic [4*NUM_TILES-1:0]  ble_o;
    cfg_state_e              dbg_state;
    logic [CNT_W-1:0]        dbg_cnt;

    logic_box_cfg_loader_if cfg_if ();

    logic_box_cfg_loader #(.NUM_TILES(NUM_TILES)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .cfg                    (cfg_if),
        .lut_o                  (lut_o),
        .sel_o                  (sel_o),
        .sel_direction_o        (dir_o),
        .sel_direction_BLEout_o (ble_o),
        .dbg_state_o            (dbg_state),
        .dbg_bit_cnt_o          (dbg_cnt)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [WORD_W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int last_cyc = 0;
    logic prev_done = 1'b0;
    logic [WORD_W-1:0] hold_exp = '0;

    function automatic logic [WORD_W-1:0] cur_word();
        return {lut_o, sel_o, dir_o, ble_o};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cfg_done pulse pops one expected configuration
    always @(negedge clk) begin
        if (!reset && cfg_if.cfg_done) begin
            done_cnt++;
            check("done_width", 64'(prev_done), 64'(0));
            check("done_latency", 64'(cyc - last_cyc), 64'(2));
            check("busy_at_done", 64'(cfg_if.cfg_busy), 64'(0));
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got cfg %h with empty queue", cur_word());
            end else begin
                check("commit_cfg", 64'(cur_word()), 64'(exp_q.pop_front()));
            end
        end
        prev_done = cfg_if.cfg_done;
    end

    // Driver tasks: all enter and leave at a falling edge
    task automatic do_start();
        cfg_if.cfg_start = 1'b1;
        @(negedge clk);
        cfg_if.cfg_start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        int guard;
        guard = 0;
        for (int g = 0; g < gap; g++) begin
            cfg_if.cfg_valid = 1'b0;
            @(negedge clk);
        end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = b;
        while (!cfg_if.cfg_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("ready_timeout", 64'(cfg_if.cfg_ready), 64'(1));
        last_cyc = cyc;
        @(negedge clk);
    endtask

    // Sends bits hi..lo of a stream; the parity bit follows when lo reaches 0
    task automatic send_stream(input logic [PAYLOAD_W-1:0] s, input int hi, input int lo,
                               input int max_gap, input logic bad_par, input bit chk_hold);
        for (int i = hi; i >= lo; i--) begin
            send_bit(s[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
            if (chk_hold) check("hold_until_done", 64'(cur_word()), 64'(hold_exp));
        end
`ifdef CFG_PARITY_EN
        if (lo == 0) send_bit((^s) ^ bad_par, 0);
`else
        if (bad_par && lo == 0) $display("note: parity disabled, no parity bit sent");
`endif
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (done_cnt < target && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 64'(done_cnt), 64'(target));
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        int dt;
        dt = 0;
        cfg_if.cfg_start = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_cfg_word", 64'(cur_word()), 64'(0));
        check("rst_ready", 64'(cfg_if.cfg_ready), 64'(0));
        check("rst_busy", 64'(cfg_if.cfg_busy), 64'(0));
        check("rst_done", 64'(cfg_if.cfg_done), 64'(0));
        check("rst_err", 64'(cfg_if.cfg_err), 64'(0));
        check("rst_active", 64'(cfg_if.cfg_active), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(IDLE));

        // cfg_valid in IDLE is ignored
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_cnt", 64'(dbg_cnt), 64'(0));
        check("idle_state", 64'(dbg_state), 64'(IDLE));
        cfg_if.cfg_valid = 1'b0;
        @(negedge clk);

        // Continuous load of A
        do_start();
        check("start_ready", 64'(cfg_if.cfg_ready), 64'(1));
        check("start_busy", 64'(cfg_if.cfg_busy), 64'(1));
        exp_q.push_back(WORD_A);
        send_stream(STREAM_A, PAYLOAD_W - 1, 0, 0, 1'b0, 1'b0);
        dt++;
        wait_done(dt);
        check("a_lut", 64'(lut_o), 64'(32'h8001A5A5));
        check("a_ble", 64'(ble_o), 64'(8'h81));
        check("a_dir", 64'(dir_o), 64'(4'b0110));
        check("a_sel", 64'(sel_o), 64'(2'b01));
        check("a_active", 64'(cfg_if.cfg_active), 64'(1));
        check("a_err", 64'(cfg_if.cfg_err), 64'(0));

        // Continuous load of B; A must hold until cfg_done
        hold_exp = WORD_A;
        do_start();
        exp_q.push_back(WORD_B);
        send_stream(STREAM_B, PAYLOAD_W - 1, 0, 0, 1'b0, 1'b1);
        dt++;
        wait_done(dt);

        // A again with random valid gaps; B must hold until cfg_done
        hold_exp = WORD_B;
        do_start();
        exp_q.push_back(WORD_A);
        send_stream(STREAM_A, PAYLOAD_W - 1, 0, 3, 1'b0, 1'b1);
        dt++;
        wait_done(dt);

        // cfg_start mid-SHIFT is ignored; load of B completes
        hold_exp = WORD_A;
        do_start();
        exp_q.push_back(WORD_B);
        send_stream(STREAM_B, PAYLOAD_W - 1, PAYLOAD_W - 5, 0, 1'b0, 1'b1);
        do_start();
        check("midstart_cnt", 64'(dbg_cnt), 64'(5));
        check("midstart_state", 64'(dbg_state), 64'(SHIFT));
        send_stream(STREAM_B, PAYLOAD_W - 6, 0, 0, 1'b0, 1'b1);
        dt++;
        wait_done(dt);

`ifdef CFG_PARITY_EN
        // Flipped parity bit: error, no commit, B retained
        do_start();
        send_stream(STREAM_A, PAYLOAD_W - 1, 0, 0, 1'b1, 1'b0);
        check("par_err", 64'(cfg_if.cfg_err), 64'(1));
        check("par_busy", 64'(cfg_if.cfg_busy), 64'(0));
        repeat (4) @(negedge clk);
        check("par_no_done", 64'(done_cnt), 64'(dt));
        check("par_keep_cfg", 64'(cur_word()), 64'(WORD_B));
        check("par_err_sticky", 64'(cfg_if.cfg_err), 64'(1));
        do_start();
        check("par_err_clear", 64'(cfg_if.cfg_err), 64'(0));
        exp_q.push_back(WORD_A);
        send_stream(STREAM_A, PAYLOAD_W - 1, 0, 0, 1'b0, 1'b0);
        dt++;
        wait_done(dt);
`endif
        check("err_clean", 64'(cfg_if.cfg_err), 64'(0));

        // Reset after 10 bits of a load
        do_start();
        send_stream(STREAM_B, PAYLOAD_W - 1, PAYLOAD_W - 10, 0, 1'b0, 1'b0);
        check("pre_rst_cnt", 64'(dbg_cnt), 64'(10));
        reset = 1'b1;
        @(negedge clk);
        check("midrst_cfg", 64'(cur_word()), 64'(0));
        check("midrst_active", 64'(cfg_if.cfg_active), 64'(0));
        check("midrst_busy", 64'(cfg_if.cfg_busy), 64'(0));
        check("midrst_cnt", 64'(dbg_cnt), 64'(0));
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("no_stray_done", 64'(done_cnt), 64'(dt));
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_box_cfg_loader.md
# logic_box_cfg_loader

Serial configuration loader for an array of `NUM_TILES` logic boxes. It receives a bitstream over a valid/ready serial port and assembles it in a shadow shift register. It then commits the result atomically to the per-tile configuration outputs: `lut`, `sel`, `sel_direction` and `sel_direction_BLEout`. It sits directly upstream of the logic boxes and drives their configuration inputs, so a tile never sees a partially loaded configuration.

## Interface
- `NUM_TILES`, 4: number of logic boxes configured; ≥1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cfg_start` in 1: one-cycle pulse that begins a load; honoured only in IDLE.
- `cfg_data` in 1: serial configuration bit.
- `cfg_valid` in 1: `cfg_data` is valid.
- `cfg_ready` out 1: loader accepts a bit this cycle.
- `cfg_busy` out 1: state is not IDLE.
- `cfg_done` out 1: one-cycle pulse; new configuration is visible on the outputs.
- `cfg_err` out 1: sticky parity error; cleared by `cfg_start` or `reset`.
- `cfg_active` out 1: at least one configuration committed since reset.
- `lut_o` out 16*NUM_TILES: tile t occupies bits [16t+15:16t].
- `sel_o` out NUM_TILES: tile t occupies bit t.
- `sel_direction_o` out 2*NUM_TILES: tile t occupies bits [2t+1:2t].
- `sel_direction_BLEout_o` out 4*NUM_TILES: tile t occupies bits [4t+3:4t].

## Operation
- Frame per tile is 23 bits, sent MSB-first in this order: `sel_direction_BLEout[3:0]`, `sel_direction[1:0]`, `sel`, `lut[15:0]`.
- Tile 0 is sent first. Total payload is `NUM_TILES*23` bits.
- A bit is accepted when `cfg_valid && cfg_ready`. It shifts into the shadow register and increments the bit counter.
- The counter is wide enough for `NUM_TILES*23` (+1 with parity).
- States:
  - IDLE: `cfg_ready`=0. On `cfg_start`: clear counter and shadow, clear `cfg_err`, go to SHIFT.
  - SHIFT: `cfg_ready`=1. After the last payload bit is accepted, go to PARITY if `CFG_PARITY_EN`, otherwise go to COMMIT.
  - PARITY: `cfg_ready`=1. Accept one bit. If the XOR of all payload bits and the parity bit is 0 (even parity), go to COMMIT. Otherwise set `cfg_err` and go to IDLE with no commit.
  - COMMIT: copy shadow to the output registers, set `cfg_active`, pulse `cfg_done`, go to IDLE.
- `cfg_start` outside IDLE is ignored; there is no restart mid-load.
- `cfg_valid` outside SHIFT/PARITY is ignored; no bit is consumed.
- Output registers change only in COMMIT. A failed or incomplete load leaves the previous configuration intact.
- Reset values: all configuration outputs 0, `cfg_ready`/`cfg_busy`/`cfg_done`/`cfg_err`/`cfg_active` all 0, state IDLE.
- Reset mid-load discards the shadow and clears the active outputs to 0.

## Timing
- Cycle S has `cfg_start` high in IDLE. `cfg_ready` and `cfg_busy` are high from S+1.
- Cycle L is the acceptance of the last bit (payload, or parity when enabled). COMMIT occupies L+1.
- In L+2, outputs hold the new values and `cfg_done`=1 for exactly one cycle. `cfg_busy` is 0 in L+2.
- Minimum load with continuous `cfg_valid` is `NUM_TILES*23` (+1) cycles, plus 2 cycles of overhead.
- On a parity error, `cfg_err`=1 from L+1. `cfg_busy`=0 from L+1.
- `cfg_start` is accepted again from L+2.
- `cfg_valid` gaps stall the counter with no timeout.

## Configuration
- `CFG_PARITY_EN` defined:
  - PARITY state exists and a trailing even-parity bit is expected.
  - `cfg_err` is functional.
- `CFG_PARITY_EN` undefined:
  - No PARITY state; SHIFT goes straight to COMMIT.
  - `cfg_err` is tied to 0.
  - Bit count is exactly `NUM_TILES*23`.

## Structure
- Package `logic_box_cfg_pkg` holds:
  - `CFG_FRAME_W`=23.
  - Field widths and offsets: BLEout 4, direction 2, sel 1, lut 16.
  - The state enum {IDLE, SHIFT, PARITY, COMMIT}.
- Sub-module `logic_box_cfg_unpack` is purely combinational. It slices one 23-bit frame into the four fields and is instantiated once per tile on the shadow register.
- The top level contains the FSM, counter, shadow, parity accumulator and output registers.

## Test plan
- Reset and idle checks, with `NUM_TILES`=2:
  - After reset, all outputs are 0.
  - `cfg_valid`=1 in IDLE is ignored; the bit counter stays 0.
- Continuous load, `NUM_TILES`=2:
  - Stimulus: tile0 = BLEout 4'b0001, dir 2'b10, sel 1, lut 16'hA5A5; tile1 = BLEout 4'b1000, dir 2'b01, sel 0, lut 16'h8001. Parity bit correct when enabled.
  - Expected: `lut_o`=32'h8001A5A5, `sel_direction_BLEout_o`=8'h81, `sel_direction_o`=4'b0110, `sel_o`=2'b01.
  - Expected: `cfg_done` pulses one cycle, 2 cycles after the last bit.
- Random `cfg_valid` gaps on the same stream → identical outputs. Outputs hold their previous values until `cfg_done`.
- `CFG_PARITY_EN`, flipped parity bit:
  - `cfg_err`=1 and no `cfg_done`.
  - Outputs keep the prior configuration.
  - Next `cfg_start` clears `cfg_err`.
- `reset` asserted after 10 bits of a load following a successful load → all outputs 0 and `cfg_active`=0 next cycle.
- `cfg_start` pulsed mid-SHIFT → ignored; the load completes with the original stream.
